sample_burst_controller: RTL

Sequences a burst of N test samples from the 16-bit random sample source into the echo-cancellation datapath under a valid/ready handshake. Inserts a programmable inter-sample gap to emulate the sampling rate. Reports progress and completion. Sits between the stimulus source and the canceller input in the test harness.

---
 rtl/sample_burst_controller.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sample_burst_controller.sv
// Burst sequencer: moves N samples from the random source into the
// canceller input under a valid/ready handshake, with a programmable
// idle gap between an accepted sample and the next load.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start; start with N=0 only produces a done pulse
// LOAD     | capture src_signal into out_sample, pulse src_adv
// WAIT_ACK | out_sample/out_valid held until out_ready
// GAP      | counting down the inter-sample gap before the next LOAD
module sample_burst_controller #(
    parameter int CNT_W  = 16,
    parameter int GAP_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk_sampling,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  n_samples,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic [DATA_W-1:0] src_signal,
    output logic              src_adv,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  sample_idx
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   out_sample_q, out_sample_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    sample_idx_q, sample_idx_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [GAP_W-1:0]    cnt_q, cnt_d;

    logic                handshake;
    logic [CNT_W-1:0]    idx_inc;

    assign handshake = out_valid_q & out_ready;
    assign idx_inc   = sample_idx_q + CNT_W'(1);

    // State and datapath registers, synchronous active-high reset.
    always_ff @(posedge clk_sampling) begin
        if (reset) begin
            state_q      <= S_IDLE;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
            sample_idx_q <= '0;
            n_q          <= '0;
            gap_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
            sample_idx_q <= sample_idx_d;
            n_q          <= n_d;
            gap_q        <= gap_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and next-datapath decode; abort outranks everything but reset,
    // while a handshake in the abort cycle still counts.
    always_comb begin
        state_d      = state_q;
        out_sample_d = out_sample_q;
        out_valid_d  = out_valid_q;
        done_d       = 1'b0;
        sample_idx_d = sample_idx_q;
        n_d          = n_q;
        gap_d        = gap_q;
        cnt_d        = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (n_samples != '0) begin
                        n_d          = n_samples;
                        gap_d        = gap_cycles;
                        sample_idx_d = '0;
                        state_d      = S_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (abort) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    out_sample_d = src_signal;
                    out_valid_d  = 1'b1;
                    state_d      = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (handshake) begin
                    out_valid_d  = 1'b0;
                    sample_idx_d = idx_inc;
                end
                if (abort) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end else if (handshake) begin
                    if (idx_inc == n_q) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (gap_q == '0) begin
                        state_d = S_LOAD;
                    end else begin
                        cnt_d   = gap_q;
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == GAP_W'(1)) begin
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q - GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: src_adv only when the load actually happens.
    always_comb begin
        src_adv    = (state_q == S_LOAD) && !abort && !reset;
        busy       = (state_q != S_IDLE);
        out_sample = out_sample_q;
        out_valid  = out_valid_q;
        done       = done_q;
        sample_idx = sample_idx_q;
    end

endmodule
